// File: rtl/rob_retire_unit.sv
// rob_retire_unit: two-wide reorder buffer with in-order retirement.
//
// It holds in-flight instructions in program order, writes up to two entries per cycle at
// the tail and marks entries complete from two CDB ports. Up to two completed entries
// retire per cycle from the head. If a mispredicted branch retires, the unit raises
// branch_recover_o and flushes every entry at that edge.
//
// Ports:
//   clk, reset_n                  clock (rising edge) and asynchronous active-low reset
//   dispatch_*_i, dispatch_idx_o  write side: per-slot valid and payload, and the assigned
//                                 entry index of each slot (tail, tail+1)
//   rob_free_o                    free entries (0..ROB_DEPTH), taken from registered count
//   complete_*_i                  CDB completion valid, entry index and mispredict flag
//   retire_*_o                    retire stream for the architectural table and free list
//   branch_recover_o              bit j: retire slot j is a mispredicted branch
//   retire_count_o                running retired-instruction count; this port exists only
//                                 when ROB_RETIRE_CNT_EN is defined
//
// Optional macro: ROB_RETIRE_CNT_EN
//   Adds the 32-bit retired-instruction counter. A recovery does not clear it.

`ifndef ARCHREG_NUMBER
`define ARCHREG_NUMBER 32
`endif
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

module rob_retire_unit #(
    parameter int unsigned ROB_DEPTH  = 32,
    parameter int unsigned ARCH_W     = $clog2(`ARCHREG_NUMBER),
    parameter int unsigned PREG_W     = $clog2(`PREG_NUMBER),
    parameter int unsigned DEST_SEL_W = 1    // width of a DEST_REG_SEL code
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
`ifdef ROB_RETIRE_CNT_EN
    output logic [31:0]                            retire_count_o,
`endif
    input  logic [1:0]                             dispatch_en_i,
    input  logic [1:0][ARCH_W-1:0]                 dispatch_arch_reg_i,
    input  logic [1:0][PREG_W-1:0]                 dispatch_new_tag_i,
    input  logic [1:0][PREG_W-1:0]                 dispatch_old_tag_i,
    input  logic [1:0][DEST_SEL_W-1:0]             dispatch_dest_sel_i,
    output logic [1:0][$clog2(ROB_DEPTH)-1:0]      dispatch_idx_o,
    output logic [$clog2(ROB_DEPTH):0]             rob_free_o,
    input  logic [1:0]                             complete_en_i,
    input  logic [1:0][$clog2(ROB_DEPTH)-1:0]      complete_idx_i,
    input  logic [1:0]                             complete_mispredict_i,
    output logic [1:0]                             retire_en_o,
    output logic [1:0][ARCH_W-1:0]                 retire_arch_reg_o,
    output logic [1:0][PREG_W-1:0]                 retire_new_tag_o,
    output logic [1:0][PREG_W-1:0]                 retire_old_tag_o,
    output logic [1:0][DEST_SEL_W-1:0]             retire_dest_sel_o,
    output logic [1:0]                             branch_recover_o
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    typedef logic [IDX_W-1:0] idx_t;

    logic [ROB_DEPTH-1:0]  valid_q, valid_d, done_q, done_d, mis_q, mis_d;
    logic [ARCH_W-1:0]     arch_q [ROB_DEPTH];
    logic [PREG_W-1:0]     new_q  [ROB_DEPTH];
    logic [PREG_W-1:0]     old_q  [ROB_DEPTH];
    logic [DEST_SEL_W-1:0] dest_q [ROB_DEPTH];

    idx_t             head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ret0, ret1, acc0, acc1, flush;
    logic [1:0]       recover;

    // Retire and dispatch decisions come from registered state only.
    always_comb begin
        head1   = head_q + idx_t'(1);
        tail1   = tail_q + idx_t'(1);
        ret0    = valid_q[head_q] & done_q[head_q];
        // A mispredicted head blocks slot1: younger work is on the wrong path.
        ret1    = ret0 & ~mis_q[head_q] & valid_q[head1] & done_q[head1];
        recover = {ret1 & mis_q[head1], ret0 & mis_q[head_q]};
        flush   = |recover;

        rob_free_o = CNT_W'(ROB_DEPTH) - count_q;
        acc0 = dispatch_en_i[0] & (rob_free_o != '0);
        acc1 = acc0 & dispatch_en_i[1] & (rob_free_o > CNT_W'(1));

        dispatch_idx_o[0] = tail_q;
        dispatch_idx_o[1] = tail1;

        retire_en_o          = {ret1, ret0};
        branch_recover_o     = recover;
        retire_arch_reg_o[0] = arch_q[head_q];
        retire_arch_reg_o[1] = arch_q[head1];
        retire_new_tag_o[0]  = new_q[head_q];
        retire_new_tag_o[1]  = new_q[head1];
        retire_old_tag_o[0]  = old_q[head_q];
        retire_old_tag_o[1]  = old_q[head1];
        retire_dest_sel_o[0] = dest_q[head_q];
        retire_dest_sel_o[1] = dest_q[head1];
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        mis_d   = mis_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // The flags are ORed so two ports that hit one entry both take effect.
        for (int p = 0; p < 2; p++) begin
            if (complete_en_i[p] && valid_q[complete_idx_i[p]]) begin
                done_d[complete_idx_i[p]] = 1'b1;
                mis_d[complete_idx_i[p]]  = mis_d[complete_idx_i[p]] | complete_mispredict_i[p];
            end
        end
        if (ret0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            mis_d[head_q]   = 1'b0;
        end
        if (ret1) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
            mis_d[head1]   = 1'b0;
        end
        if (acc0) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            mis_d[tail_q]   = 1'b0;
        end
        if (acc1) begin
            valid_d[tail1] = 1'b1;
            done_d[tail1]  = 1'b0;
            mis_d[tail1]   = 1'b0;
        end
        head_d  = ret1 ? head_q + idx_t'(2) : (ret0 ? head1 : head_q);
        tail_d  = acc1 ? tail_q + idx_t'(2) : (acc0 ? tail1 : tail_q);
        count_d = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(ret0) - CNT_W'(ret1);

        // A recovery discards the same-cycle dispatches and completions too.
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            mis_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            done_q  <= '0;
            mis_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (acc0) begin
            arch_q[tail_q] <= dispatch_arch_reg_i[0];
            new_q[tail_q]  <= dispatch_new_tag_i[0];
            old_q[tail_q]  <= dispatch_old_tag_i[0];
            dest_q[tail_q] <= dispatch_dest_sel_i[0];
        end
        if (acc1) begin
            arch_q[tail1] <= dispatch_arch_reg_i[1];
            new_q[tail1]  <= dispatch_new_tag_i[1];
            old_q[tail1]  <= dispatch_old_tag_i[1];
            dest_q[tail1] <= dispatch_dest_sel_i[1];
        end
    end

`ifdef ROB_RETIRE_CNT_EN
    logic [31:0] retire_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_q + 32'(ret0) + 32'(ret1);
        end
    end

    assign retire_count_o = retire_count_q;
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
module tb_rob_retire_unit;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] dispatch_en_i = '0;
    logic [1:0][AW-1:0] dispatch_arch_reg_i = '0;
    logic [1:0][PW-1:0] dispatch_new_tag_i = '0;
    logic [1:0][PW-1:0] dispatch_old_tag_i = '0;
    logic [1:0][0:0] dispatch_dest_sel_i = '0;
    logic [1:0][4:0] dispatch_idx_o;
    logic [5:0] rob_free_o;
    logic [1:0] complete_en_i = '0;
    logic [1:0][4:0] complete_idx_i = '0;
    logic [1:0] complete_mispredict_i = '0;
    logic [1:0] retire_en_o;
    logic [1:0][AW-1:0] retire_arch_reg_o;
    logic [1:0][PW-1:0] retire_new_tag_o;
    logic [1:0][PW-1:0] retire_old_tag_o;
    logic [1:0][0:0] retire_dest_sel_o;
    logic [1:0] branch_recover_o;
`ifdef ROB_RETIRE_CNT_EN
    logic [31:0] retire_count_o;
`endif

    rob_retire_unit #(.ROB_DEPTH(DEPTH), .ARCH_W(AW), .PREG_W(PW), .DEST_SEL_W(1)) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef ROB_RETIRE_CNT_EN
        .retire_count_o(retire_count_o),
`endif
        .dispatch_en_i(dispatch_en_i), .dispatch_arch_reg_i(dispatch_arch_reg_i),
        .dispatch_new_tag_i(dispatch_new_tag_i), .dispatch_old_tag_i(dispatch_old_tag_i),
        .dispatch_dest_sel_i(dispatch_dest_sel_i), .dispatch_idx_o(dispatch_idx_o),
        .rob_free_o(rob_free_o), .complete_en_i(complete_en_i),
        .complete_idx_i(complete_idx_i), .complete_mispredict_i(complete_mispredict_i),
        .retire_en_o(retire_en_o), .retire_arch_reg_o(retire_arch_reg_o),
        .retire_new_tag_o(retire_new_tag_o), .retire_old_tag_o(retire_old_tag_o),
        .retire_dest_sel_o(retire_dest_sel_o), .branch_recover_o(branch_recover_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx; int arch; int nt; int ot; int dest; bit done; bit mis;
    } ent_t;
    typedef struct { int free; int d0; int d1; int ren; int rec; longint cnt; } cyc_t;
    typedef struct { int arch; int nt; int ot; int dest; } ret_t;

    ent_t rob_q[$];     // model: in-flight instructions, oldest first
    cyc_t exp_q[$];     // expected per-cycle outputs
    ret_t ret_q[$];     // expected retire stream in program order
    int tail = 0;
    longint model_cnt = 0;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each cycle's outputs and pops the retire stream on retire_en_o.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cyc_t e;
                e = exp_q.pop_front();
                chk("rob_free", rob_free_o, e.free);
                chk("dispatch_idx0", dispatch_idx_o[0], e.d0);
                chk("dispatch_idx1", dispatch_idx_o[1], e.d1);
                chk("retire_en", retire_en_o, e.ren);
                chk("branch_recover", branch_recover_o, e.rec);
`ifdef ROB_RETIRE_CNT_EN
                chk("retire_count", retire_count_o, e.cnt);
`endif
                for (int j = 0; j < 2; j++) begin
                    if (retire_en_o[j]) begin
                        if (ret_q.size() == 0) begin
                            chk("retire_unexpected", 1, 0);
                        end else begin
                            ret_t r;
                            r = ret_q.pop_front();
                            chk("retire_arch", retire_arch_reg_o[j], r.arch);
                            chk("retire_new_tag", retire_new_tag_o[j], r.nt);
                            chk("retire_old_tag", retire_old_tag_o[j], r.ot);
                            chk("retire_dest", retire_dest_sel_o[j], r.dest);
                        end
                    end
                end
            end
        end
    end

    // One cycle: record expected outputs from the model, drive inputs, advance the model.
    task automatic step(input logic [1:0] den, input logic [1:0][AW-1:0] arch,
                        input logic [1:0][PW-1:0] nt, input logic [1:0][PW-1:0] ot,
                        input logic [1:0] dest, input logic [1:0] cen,
                        input int ci0, input int ci1, input logic [1:0] cmis);
        cyc_t e;
        int n;
        int free;
        bit r0, r1;
        int ci[2];
        @(posedge clk);
        #2;
        n = rob_q.size();
        free = DEPTH - n;
        r0 = n > 0 && rob_q[0].done;
        r1 = r0 && !rob_q[0].mis && n > 1 && rob_q[1].done;
        e.free = free;
        e.d0 = tail;
        e.d1 = (tail + 1) % DEPTH;
        e.ren = {30'd0, r1, r0};
        e.rec = {30'd0, r1 && rob_q[1].mis, r0 && rob_q[0].mis};
        e.cnt = model_cnt;
        exp_q.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if ((k == 0 && r0) || (k == 1 && r1)) begin
                ret_t r;
                r.arch = rob_q[k].arch; r.nt = rob_q[k].nt;
                r.ot = rob_q[k].ot; r.dest = rob_q[k].dest;
                ret_q.push_back(r);
            end
        end

        dispatch_en_i = den;
        dispatch_arch_reg_i = arch;
        dispatch_new_tag_i = nt;
        dispatch_old_tag_i = ot;
        dispatch_dest_sel_i[0] = dest[0];
        dispatch_dest_sel_i[1] = dest[1];
        complete_en_i = cen;
        complete_idx_i[0] = 5'(ci0);
        complete_idx_i[1] = 5'(ci1);
        complete_mispredict_i = cmis;

        ci[0] = ci0;
        ci[1] = ci1;
        for (int p = 0; p < 2; p++) begin
            if (cen[p]) begin
                for (int k = 0; k < rob_q.size(); k++) begin
                    if (rob_q[k].idx == ci[p]) begin
                        ent_t t;
                        t = rob_q[k];
                        t.done = 1;
                        t.mis = t.mis | cmis[p];
                        rob_q[k] = t;
                    end
                end
            end
        end
        model_cnt = (model_cnt + r0 + r1) % (64'd1 << 32);
        if (e.rec != 0) begin
            rob_q.delete();
            tail = 0;
        end else begin
            if (r0) void'(rob_q.pop_front());
            if (r1) void'(rob_q.pop_front());
            for (int k = 0; k < 2; k++) begin
                if (den[0] && den[k] && free > k) begin
                    ent_t t;
                    t.idx = tail; t.arch = arch[k]; t.nt = nt[k]; t.ot = ot[k];
                    t.dest = dest[k]; t.done = 0; t.mis = 0;
                    rob_q.push_back(t);
                    tail = (tail + 1) % DEPTH;
                end
            end
        end
    endtask

    task automatic rstep(input logic [1:0] den, input logic [1:0] cen, input int ci0,
                         input int ci1, input logic [1:0] cmis);
        logic [1:0][AW-1:0] a;
        logic [1:0][PW-1:0] nt, ot;
        logic [1:0] d;
        for (int k = 0; k < 2; k++) begin
            a[k] = AW'($urandom);
            nt[k] = PW'($urandom);
            ot[k] = PW'($urandom);
            d[k] = 1'($urandom);
        end
        step(den, a, nt, ot, d, cen, ci0, ci1, cmis);
    endtask

    // Completes the two oldest incomplete entries each cycle until the ROB is empty.
    task automatic drain();
        for (int c = 0; c < 40 && rob_q.size() > 0; c++) begin
            int found[$];
            logic [1:0] cen;
            for (int k = 0; k < rob_q.size() && found.size() < 2; k++)
                if (!rob_q[k].done) found.push_back(rob_q[k].idx);
            cen = {found.size() > 1, found.size() > 0};
            rstep(2'b00, cen, found.size() > 0 ? found[0] : 0,
                  found.size() > 1 ? found[1] : 0, 2'b00);
        end
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
    endtask

    initial begin
        int a_idx;
        // Reset state, checked while reset is held.
        #1;
        chk("reset_free", rob_free_o, DEPTH);
        chk("reset_retire_en", retire_en_o, 0);
        chk("reset_dispatch_idx1", dispatch_idx_o[1], 1);
        #2 reset_n = 1'b1;

        // Two-instruction completion out of order, paired retire.
        step(2'b11, {5'd6, 5'd5}, {6'd41, 6'd40}, {6'd6, 6'd5}, 2'b00, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b01, 1, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b01, 0, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);

        // Mispredicted head with a complete younger entry: only slot0 retires.
        a_idx = tail;
        rstep(2'b11, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b11, a_idx, (a_idx + 1) % DEPTH, 2'b01);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);

        // Mispredicted slot1 with a dispatch in the recovery cycle.
        a_idx = tail;
        rstep(2'b11, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b11, a_idx, (a_idx + 1) % DEPTH, 2'b10);
        rstep(2'b11, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b00, 0, 0, 2'b00);

        // Fill to full, keep requesting, then drain.
        for (int c = 0; c < 18; c++) rstep(2'b11, 2'b00, 0, 0, 2'b00);
        drain();

        // Move head and tail to 30, then dispatch across the wrap.
        for (int c = 0; c < 15; c++) rstep(2'b11, 2'b00, 0, 0, 2'b00);
        drain();
        rstep(2'b11, 2'b00, 0, 0, 2'b00);
        rstep(2'b11, 2'b00, 0, 0, 2'b00);
        drain();

        // Ten valid entries, then an asynchronous reset between clock edges.
        for (int c = 0; c < 5; c++) rstep(2'b11, 2'b00, 0, 0, 2'b00);
        rstep(2'b00, 2'b01, tail - 10, 0, 2'b00);
        @(negedge clk);
        #1;
        dispatch_en_i = '0;
        complete_en_i = '0;
        reset_n = 1'b0;
        #1;
        chk("async_reset_free", rob_free_o, DEPTH);
        chk("async_reset_retire_en", retire_en_o, 0);
`ifdef ROB_RETIRE_CNT_EN
        chk("async_reset_count", retire_count_o, 0);
`endif
        #1 reset_n = 1'b1;
        rob_q.delete();
        ret_q.delete();
        tail = 0;
        model_cnt = 0;

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            logic [1:0] den, cen, cmis;
            int ci[2];
            case ($urandom % 3)
                0: den = 2'b00;
                1: den = 2'b01;
                default: den = 2'b11;
            endcase
            cen = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                if (rob_q.size() > 0 && ($urandom % 8) != 0)
                    ci[p] = rob_q[$urandom % rob_q.size()].idx;
                else
                    ci[p] = $urandom % DEPTH;
            end
            cmis = {($urandom % 12) == 0, ($urandom % 12) == 0};
            rstep(den, cen, ci[0], ci[1], cmis);
        end
        rstep(2'b00, 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- Two-wide reorder buffer holding in-flight instructions in program order.
- Produces the in-order retire stream (arch reg, new/old tag, dest select, branch recover) consumed by the architectural table and free list.
- On a mispredicted branch reaching retirement, it signals recovery and flushes itself.
- Sits between dispatch/rename (write side), the complete stage (CDB) and the commit-side tables.

Parameters:
- ROB_DEPTH, 32, number of entries; power of two, ≥4.
- ARCH_W, $clog2(`ARCHREG_NUMBER), arch register index width.
- PREG_W, $clog2(`PREG_NUMBER), physical tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dispatch_en_i  in  2  per-slot dispatch valid; slot1 legal only with slot0.
- dispatch_arch_reg_i  in  2×ARCH_W  destination arch reg.
- dispatch_new_tag_i  in  2×PREG_W  newly allocated physical tag.
- dispatch_old_tag_i  in  2×PREG_W  previous mapping, returned to free list at retire.
- dispatch_dest_sel_i  in  2×DEST_REG_SEL  DEST_RD or no destination.
- dispatch_idx_o  out  2×$clog2(ROB_DEPTH)  entry index assigned to each dispatch slot (tail, tail+1).
- rob_free_o  out  $clog2(ROB_DEPTH)+1  free entries, 0..ROB_DEPTH.
- complete_en_i  in  2  CDB completion valid.
- complete_idx_i  in  2×$clog2(ROB_DEPTH)  completing entry index.
- complete_mispredict_i  in  2  entry is a mispredicted branch.
- retire_en_o  out  2  retire valid per slot.
- retire_arch_reg_o  out  2×ARCH_W.
- retire_new_tag_o  out  2×PREG_W.
- retire_old_tag_o  out  2×PREG_W.
- retire_dest_sel_o  out  2×DEST_REG_SEL.
- branch_recover_o  out  2  bit j: retire slot j is a mispredicted branch.

Behaviour:
- State: entry array (valid, complete, mispredict, payload); head, tail pointers of $clog2(ROB_DEPTH) bits, wrapping naturally; count register.
- Reset (async, reset_n=0): head=tail=0, count=0, all valid/complete/mispredict cleared. Outputs: retire_en_o=0, branch_recover_o=0, rob_free_o=ROB_DEPTH, dispatch_idx_o={1,0}.
- Dispatch:
  - Slot j is written at the clock edge when dispatch_en_i[j]=1 and rob_free_o>j.
  - Excess requests are silently dropped; upstream must stall on rob_free_o.
  - A new entry is written with complete=0 and tail advances by the number accepted.
- Complete:
  - At the edge, sets complete (and mispredict) for the indexed valid entry.
  - A completion to an invalid entry is ignored.
  - Both ports hitting the same index: OR the flags.
- Retire (combinational from registered state):
  - Slot0 retires when the head entry is valid and complete.
  - Slot1 retires when head+1 is valid and complete, slot0 retires, and slot0 is not mispredicted.
  - Completion-to-retire latency is 1 cycle minimum.
- Recovery:
  - Head mispredicted → retire_en_o[0]=1, branch_recover_o=2'b01, retire_en_o[1]=0.
  - Slot1 mispredicted (slot0 clean) → branch_recover_o=2'b10, both retire.
  - On any recover bit, at the edge all entries are invalidated; head=tail=0, count=0. Same-cycle dispatches and completions are discarded.
  - Next cycle rob_free_o=ROB_DEPTH.
- Count update: count_next = count + accepted − retired, unless recovery.
- Simultaneous events: retirement frees slots only at the edge, so free slots are not reusable for a dispatch in the same cycle. rob_free_o is computed from registered count only.
- Full (count=ROB_DEPTH): no dispatch accepted; retire still proceeds.
- Empty: retire_en_o=0.
- Retire outputs for slots with retire_en_o=0 are don't-care; verification checks them only when valid.

Optional Feature:
- ROB_RETIRE_CNT_EN
  - Defined: adds output retire_count_o[31:0], reset to 0, incremented by the number of retired instructions each cycle, wrapping at 2^32; recovery does not clear it.
  - Undefined: port and counter are absent.

Test Plan:
- Reset, then dispatch 2/cycle for 16 cycles (ROB_DEPTH=32), no completions → rob_free_o reaches 0; further dispatch_en_i=2'b11 changes nothing; dispatch_idx_o wraps to {1,0}.
- Dispatch A(arch 5,new 40,old 5) and B(arch 6,new 41,old 6) in cycle 0; complete B in cycle 2, A in cycle 4 → cycle 5: retire_en_o=2'b11, retire_new_tag_o={41,40}, rob_free_o returns to 32 in cycle 6.
- Head completes with complete_mispredict_i=1 while head+1 is also complete → retire_en_o=2'b01, branch_recover_o=2'b01; next cycle rob_free_o=32 and retire_en_o=0.
- Slot1 mispredicted, slot0 clean, dispatch asserted in the same cycle → branch_recover_o=2'b10, retire_en_o=2'b11, dispatched entries discarded, head=tail=0.
- Head and tail wrap: retire 30 entries, dispatch 4 → indices 30,31,0,1 assigned; retire order preserved across the wrap.
- Assert reset_n low mid-cycle with 10 entries valid → outputs clear immediately without waiting for an edge; rob_free_o=32 and retire_en_o=0; with ROB_RETIRE_CNT_EN defined, retire_count_o=0.
